regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Arbitrates two writeback requesters, the ALU and the LSU, onto the single write port of the 32x32 integer register file. Each requester uses a valid/ready handshake. Each cycle the block grants at most one non-x0 write and drives the regfile write port from output registers. Writes to x0 are absorbed without consuming the port. Starvation of the lower-priority ALU path is bounded by a counter.

## Interface
- DATA_W, 32, writeback data width
- ADDR_W, 5, register address width
- STARVE_MAX, 4, consecutive denied ALU cycles before ALU is forced to win (range 1..15)
- clk_i  in  1  core clock
- rst_n_i  in  1  asynchronous active-low reset
- alu_valid_i  in  1  ALU writeback request
- alu_rd_i  in  ADDR_W  ALU destination register
- alu_data_i  in  DATA_W  ALU result
- alu_ready_o  out  1  ALU request accepted this cycle
- lsu_valid_i  in  1  LSU writeback request
- lsu_rd_i  in  ADDR_W  LSU destination register
- lsu_data_i  in  DATA_W  load data
- lsu_ready_o  out  1  LSU request accepted this cycle
- rd_we_o  out  1  regfile write enable (to regfile rd_we_i)
- rd_addr_o  out  ADDR_W  regfile write address
- rd_data_o  out  DATA_W  regfile write data
- conflict_o  out  1  registered pulse: both non-x0 requests valid, one stalled

## Operation
- Transfer on a requester happens when valid && ready in the same cycle. The requester holds valid, rd and data stable until accepted.
- x0 absorb: a valid request with rd==0 gets ready=1 combinationally in the same cycle, independent of arbitration. It produces no write and does not affect the starvation counter.
- Candidates are requests that are valid with rd!=0.
  - One candidate: it is granted.
  - Two candidates: LSU is granted by default. ALU is granted if starve_cnt==STARVE_MAX.
- starve_cnt (4-bit):
  - Increments when the ALU is a candidate and is denied.
  - Clears to 0 when the ALU is granted or the ALU is not a candidate.
  - Saturates at STARVE_MAX.
- On a grant, the output registers load on the next edge: rd_we_o=1, rd_addr_o=rd, rd_data_o=data. With no grant, rd_we_o=0 and rd_addr_o/rd_data_o hold their last values.
- Both requests x0 in the same cycle: both are readied, no write.
- Both candidates with the same rd: two sequential writes in grant order. Ordering the writes correctly is the requesters' responsibility.
- conflict_o=1 for one cycle after any cycle with two candidates.

## Timing
- Reset: rd_we_o=0, rd_addr_o=0, rd_data_o=0, conflict_o=0, starve_cnt=0. alu_ready_o and lsu_ready_o are forced to 0 while rst_n_i=0.
- ready_o is combinational from valid/rd/starve_cnt, with no registered ready path.
- Latency is one cycle from handshake to rd_we_o. The regfile commits on the following edge, so a value is visible on regfile read ports 2 edges after the handshake.
- Throughput is one non-x0 write per cycle, plus any number of x0 absorbs in parallel.
- Reset asserted mid-operation: outputs clear asynchronously. A write staged in the output register is lost. Requesters must re-present after reset.
- Worst-case ALU wait with continuous LSU traffic is STARVE_MAX+1 cycles from first valid to ready.

## Configuration
- REGFILE_WB_RR_EN defined:
  - starve_cnt is replaced by a 1-bit last-grant pointer.
  - With two candidates, the requester not granted last wins. Pointer reset value = ALU, so LSU wins the first conflict.
  - STARVE_MAX is ignored.
- REGFILE_WB_RR_EN undefined: fixed LSU priority with the starvation counter, as described above.

## Test plan
- After reset, ALU only: alu_rd=1, data=10. Response: alu_ready=1 same cycle; next cycle rd_we_o=1, rd_addr_o=1, rd_data_o=10.
- x0 absorb: lsu_rd=0, data=0xDEADBEEF, alu_rd=3, data=7 in the same cycle. Response: both ready=1; only rd_addr_o=3 is written; rd_we_o is never asserted for x0.
- Conflict, single cycle: ALU rd=2 and LSU rd=4 valid in the same cycle. Response: LSU writes first, ALU writes next cycle, conflict_o=1 for one cycle.
- Starvation, macro off, STARVE_MAX=4: LSU valid continuously with non-x0 rd, ALU held valid. Response: ALU ready on cycle 5, then LSU resumes.
- Round-robin, macro on: both requesters valid continuously. Response: grants alternate LSU, ALU, LSU, ALU.
- Reset pulse while rd_we_o=1: rd_we_o drops immediately, ready outputs go to 0 during reset, and no write occurs.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/LSU writeback arbiter onto the single regfile write port
// Optional macro REGFILE_WB_RR_EN: round-robin between candidates instead of LSU priority with starvation counter.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              alu_valid_i,
    input  logic [ADDR_W-1:0] alu_rd_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,
    input  logic              lsu_valid_i,
    input  logic [ADDR_W-1:0] lsu_rd_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    output logic              lsu_ready_o,
    output logic              rd_we_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              conflict_o
);

    logic alu_cand;
    logic lsu_cand;
    logic alu_win;
    logic grant_alu;
    logic grant_lsu;

    assign alu_cand = alu_valid_i && (alu_rd_i != '0);
    assign lsu_cand = lsu_valid_i && (lsu_rd_i != '0);

`ifdef REGFILE_WB_RR_EN
    // Pointer resets to "ALU granted last" so the LSU takes the first conflict.
    logic last_alu;

    assign alu_win = !last_alu;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_alu <= 1'b1;
        end else if (grant_alu) begin
            last_alu <= 1'b1;
        end else if (grant_lsu) begin
            last_alu <= 1'b0;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    assign alu_win = (starve_cnt == STARVE_LIM);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_cnt <= '0;
        end else if (alu_cand && !grant_alu) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end
`endif

    assign grant_alu = alu_cand && (!lsu_cand || alu_win);
    assign grant_lsu = lsu_cand && !grant_alu;

    // x0 requests are absorbed without touching the write port.
    assign alu_ready_o = rst_n_i && (grant_alu || (alu_valid_i && (alu_rd_i == '0)));
    assign lsu_ready_o = rst_n_i && (grant_lsu || (lsu_valid_i && (lsu_rd_i == '0)));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_we_o    <= 1'b0;
            rd_addr_o  <= '0;
            rd_data_o  <= '0;
            conflict_o <= 1'b0;
        end else begin
            rd_we_o    <= grant_alu || grant_lsu;
            conflict_o <= alu_cand && lsu_cand;
            if (grant_alu) begin
                rd_addr_o <= alu_rd_i;
                rd_data_o <= alu_data_i;
            end else if (grant_lsu) begin
                rd_addr_o <= lsu_rd_i;
                rd_data_o <= lsu_data_i;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - bench for regfile_wb_arbiter: vector table, corner sequences, random vs model
module tb_regfile_wb_arbiter;

    localparam int SMAX = 4;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        conflict;

    int tests;
    int fails;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(SMAX)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
        .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
        .rd_we_o(rd_we), .rd_addr_o(rd_addr), .rd_data_o(rd_data), .conflict_o(conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        exp_ar;
        logic        exp_lr;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_conf;
    } vec_t;

    // Reference model: expected registered outputs plus arbitration history.
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_conf;
    int          m_alu_waits;
    bit          m_alu_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_we = 1'b0; m_addr = '0; m_data = '0; m_conf = 1'b0;
        m_alu_waits = 0; m_alu_last = 1'b1;
    endtask

    // Decide grants from the rules, update the model, return expected readies.
    task automatic model_step(output logic exp_ar, output logic exp_lr);
        bit ac, lc, ga, gl, alu_turn;
        ac = alu_valid && (alu_rd != 0);
        lc = lsu_valid && (lsu_rd != 0);
`ifdef REGFILE_WB_RR_EN
        alu_turn = !m_alu_last;
`else
        alu_turn = (m_alu_waits >= SMAX);
`endif
        ga = ac && (!lc || alu_turn);
        gl = lc && !ga;
        exp_ar = ga || (alu_valid && alu_rd == 0);
        exp_lr = gl || (lsu_valid && lsu_rd == 0);
        if (ac && !ga) m_alu_waits = (m_alu_waits + 1 > SMAX) ? SMAX : m_alu_waits + 1;
        else m_alu_waits = 0;
        if (ga) m_alu_last = 1'b1;
        else if (gl) m_alu_last = 1'b0;
        m_we = ga || gl;
        m_conf = ac && lc;
        if (ga) begin m_addr = alu_rd; m_data = alu_data; end
        else if (gl) begin m_addr = lsu_rd; m_data = lsu_data; end
    endtask

    vec_t vecs[8];

    initial begin
        logic ea, el;
        logic        pa, pl;
        logic [4:0]  pa_rd, pl_rd;
        logic [31:0] pa_d, pl_d;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        check("reset_alu_ready", {31'd0, alu_ready}, 32'd0);

        //          av ard  adata          lv lrd  ldata          ar lr we addr data          conf
        vecs[0] = '{1, 1,  32'd10,        0, 0,  32'd0,         1, 0, 1, 1,  32'd10,        0};
        vecs[1] = '{1, 3,  32'd7,         1, 0,  32'hDEADBEEF,  1, 1, 1, 3,  32'd7,         0};
        vecs[2] = '{1, 2,  32'h22,        1, 4,  32'h44,        0, 1, 1, 4,  32'h44,        1};
        vecs[3] = '{1, 2,  32'h22,        0, 0,  32'd0,         1, 0, 1, 2,  32'h22,        0};
        vecs[4] = '{0, 0,  32'd0,         0, 0,  32'd0,         0, 0, 0, 2,  32'h22,        0};
        vecs[5] = '{1, 0,  32'h55,        1, 0,  32'h66,        1, 1, 0, 2,  32'h22,        0};
        vecs[6] = '{0, 9,  32'h99,        1, 31, 32'hFFFFFFFF,  0, 1, 1, 31, 32'hFFFFFFFF,  0};
        vecs[7] = '{0, 8,  32'h88,        0, 6,  32'h66,        0, 0, 0, 31, 32'hFFFFFFFF,  0};

        do_reset();
        check("reset_we", {31'd0, rd_we}, 32'd0);
        check("reset_addr", {27'd0, rd_addr}, 32'd0);
        check("reset_data", rd_data, 32'd0);
        check("reset_conflict", {31'd0, conflict}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].adata, vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
            #1;
            check($sformatf("vec%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].exp_ar});
            check($sformatf("vec%0d_lsu_ready", i), {31'd0, lsu_ready}, {31'd0, vecs[i].exp_lr});
            @(posedge clk); #1;
            check($sformatf("vec%0d_we", i), {31'd0, rd_we}, {31'd0, vecs[i].exp_we});
            check($sformatf("vec%0d_addr", i), {27'd0, rd_addr}, {27'd0, vecs[i].exp_addr});
            check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
            check($sformatf("vec%0d_conflict", i), {31'd0, conflict}, {31'd0, vecs[i].exp_conf});
            @(negedge clk);
        end

        // Continuous traffic from both sides: starvation bound or alternation.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            logic want_alu;
`ifdef REGFILE_WB_RR_EN
            want_alu = (k % 2 == 0);
`else
            want_alu = (k == SMAX + 1) || (k == 2 * (SMAX + 1));
`endif
            drive(1'b1, 5'd6, 32'd100 + k, 1'b1, 5'd5, 32'(k));
            #1;
            check($sformatf("starve%0d_alu_ready", k), {31'd0, alu_ready}, {31'd0, want_alu});
            check($sformatf("starve%0d_lsu_ready", k), {31'd0, lsu_ready}, {31'd0, !want_alu});
            @(posedge clk); #1;
            check($sformatf("starve%0d_addr", k), {27'd0, rd_addr}, want_alu ? 32'd6 : 32'd5);
            check($sformatf("starve%0d_conflict", k), {31'd0, conflict}, 32'd1);
            @(negedge clk);
        end

        // Reset pulse while a write is staged in the output register.
        do_reset();
        drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        check("rstpulse_we_before", {31'd0, rd_we}, 32'd1);
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd0, 32'h11);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstpulse_we", {31'd0, rd_we}, 32'd0);
        check("rstpulse_addr", {27'd0, rd_addr}, 32'd0);
        check("rstpulse_alu_ready", {31'd0, alu_ready}, 32'd0);
        check("rstpulse_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        @(posedge clk); #1;
        check("rstpulse_we_held", {31'd0, rd_we}, 32'd0);
        check("rstpulse_data_held", rd_data, 32'd0);
        do_reset();
        @(posedge clk); #1;
        check("rstpulse_no_write", {31'd0, rd_we}, 32'd0);

        // Random traffic with hold-until-accepted requesters against the model.
        do_reset();
        pa = 1'b0; pl = 1'b0; pa_rd = '0; pl_rd = '0; pa_d = '0; pl_d = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pa && ($urandom % 3 != 0)) begin
                pa = 1'b1;
                pa_rd = ($urandom % 5 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                pa_d = $urandom;
            end
            if (!pl && ($urandom % 3 != 0)) begin
                pl = 1'b1;
                pl_rd = ($urandom % 5 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                pl_d = $urandom;
            end
            drive(pa, pa_rd, pa_d, pl, pl_rd, pl_d);
            model_step(ea, el);
            #1;
            check("rand_alu_ready", {31'd0, alu_ready}, {31'd0, ea});
            check("rand_lsu_ready", {31'd0, lsu_ready}, {31'd0, el});
            if (ea) pa = 1'b0;
            if (el) pl = 1'b0;
            @(posedge clk); #1;
            check("rand_we", {31'd0, rd_we}, {31'd0, m_we});
            check("rand_addr", {27'd0, rd_addr}, {27'd0, m_addr});
            check("rand_data", rd_data, m_data);
            check("rand_conflict", {31'd0, conflict}, {31'd0, m_conf});
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
